// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with clock inhibit, ACK check and edge timeout
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int FREQ_HZ    = 40_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15_000
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       done_o,
  output logic       err_o
);
  localparam int INHIBIT_CYCLES = FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYCLES = FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_STOP, S_ACK, S_WAIT_IDLE
  } state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_clk_sync, r_dat_sync;
  logic            r_clk_prev;
  logic [9:0]      r_frame;
  logic [3:0]      r_bit;
  logic [IW-1:0]   r_inh;
  logic [TW-1:0]   r_to;
  logic            r_data_oe, r_done, r_err;
  logic            w_clk_s, w_dat_s, w_fall, w_active, w_fin, w_expire;
  assign w_clk_s  = r_clk_sync[1];
  assign w_dat_s  = r_dat_sync[1];
  assign w_fall   = r_clk_prev & ~w_clk_s;
  assign w_active = r_state inside {S_SEND, S_STOP, S_ACK, S_WAIT_IDLE};
  assign w_fin    = (r_state == S_WAIT_IDLE) && w_clk_s && w_dat_s;
  // A falling edge in the same cycle as expiry counts as a real edge
  assign w_expire = w_active && (r_to == '0) && !w_fall && !w_fin;
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_clk_sync <= {r_clk_sync[0], ps2_clk_i};
      r_dat_sync <= {r_dat_sync[0], ps2_data_i};
      r_clk_prev <= w_clk_s;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = tx_valid_i ? S_INHIBIT : S_IDLE;
      S_INHIBIT:   w_next = (r_inh == '0) ? S_REQ : S_INHIBIT;
      S_REQ:       w_next = S_SEND;
      S_SEND:      w_next = (w_fall && r_bit == 4'd8) ? S_STOP : S_SEND;
      S_STOP:      w_next = w_fall ? S_ACK : S_STOP;
      S_ACK:       w_next = w_fall ? S_WAIT_IDLE : S_ACK;
      S_WAIT_IDLE: w_next = w_fin ? S_IDLE : S_WAIT_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (w_expire) w_next = S_IDLE;
  end
  always_comb begin
    tx_ready_o    = (r_state == S_IDLE);
    ps2_clk_oe_o  = (r_state == S_INHIBIT);
    ps2_data_oe_o = r_data_oe;
    done_o        = r_done;
    err_o         = r_err;
  end
  // Frame bit 9 is the stop bit (1), so the STOP edge releases data like any other bit
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_frame   <= '0;
      r_bit     <= '0;
      r_inh     <= '0;
      r_to      <= '0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (tx_valid_i) begin
          r_frame   <= {1'b1, ~^tx_data_i, tx_data_i};
          r_bit     <= '0;
          r_inh     <= IW'(INHIBIT_CYCLES - 1);
          r_err     <= 1'b0;
          r_data_oe <= (INHIBIT_CYCLES == 1);
        end
        S_INHIBIT: if (r_inh != '0) begin
          r_inh <= r_inh - 1'b1;
          if (r_inh == IW'(1)) r_data_oe <= 1'b1;
        end
        S_REQ: r_to <= TW'(TIMEOUT_CYCLES - 1);
        default: begin
          r_to <= w_fall ? TW'(TIMEOUT_CYCLES - 1) : (r_to != '0) ? r_to - 1'b1 : r_to;
          if (w_fall && (r_state == S_SEND || r_state == S_STOP)) begin
            r_data_oe <= ~r_frame[r_bit];
            r_bit     <= r_bit + 1'b1;
          end
          if (w_fall && r_state == S_ACK) r_err <= w_dat_s;
          if (w_fin) r_done <= 1'b1;
          if (w_expire) begin
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_data_oe <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
